// File: rtl/spi_cmd_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_cmd_decoder: frames SPI bytes into REG/MEM command packets and issues   |
// | register writes and framebuffer writes, with inter-byte timeout recovery.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module spi_cmd_decoder #(
  parameter int TimeoutCycles = 25000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ByteRecv,
  input  logic [7:0]  ByteIn,
  output logic        RegWe,
  output logic [5:0]  RegAddr,
  output logic [23:0] RegData,
  output logic        MemWe,
  input  logic        MemAck,
  output logic [15:0] MemAddr,
  output logic [7:0]  MemData,
  output logic        Busy,
  input  logic        ErrClear,
  output logic        ErrOverrun,
  output logic        ErrBadCmd,
  output logic        ErrTimeout
);

  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_REG_PAY  = 2'd1;
  localparam logic [1:0] c_MEM_ADDR = 2'd2;
  localparam logic [1:0] c_MEM_DATA = 2'd3;

  localparam int              c_TW    = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
  localparam logic [c_TW-1:0] c_TLAST = c_TW'(TimeoutCycles - 1);

  logic [1:0]      r_state;
  logic [1:0]      r_idx;
  logic [5:0]      r_cnt;   // header argument: register index, or remaining data bytes - 1
  logic [15:0]     r_pay;
  logic [15:0]     r_ptr;   // address the next accepted data byte will be written to
  logic [c_TW-1:0] r_idle;

  logic w_tout;
  logic w_ack;
  logic w_data;
  logic w_overrun;
  logic w_bad;

  assign w_tout    = (r_state != c_IDLE) && !ByteRecv && (r_idle == c_TLAST);
  assign w_ack     = MemWe && MemAck;
  assign w_data    = ByteRecv && (r_state == c_MEM_DATA);
  assign w_overrun = w_data && MemWe && !MemAck;
  assign w_bad     = ByteRecv && (r_state == c_IDLE) && (ByteIn[7:6] == 2'b11);
  assign Busy      = (r_state != c_IDLE);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= c_IDLE;
      r_idx      <= 2'd0;
      r_cnt      <= 6'd0;
      r_pay      <= 16'd0;
      r_ptr      <= 16'd0;
      r_idle     <= '0;
      RegWe      <= 1'b0;
      RegAddr    <= 6'd0;
      RegData    <= 24'd0;
      MemWe      <= 1'b0;
      MemAddr    <= 16'd0;
      MemData    <= 8'd0;
      ErrOverrun <= 1'b0;
      ErrBadCmd  <= 1'b0;
      ErrTimeout <= 1'b0;
    end else begin
      RegWe      <= 1'b0;
      // A new error event in the same cycle as ErrClear keeps the flag set
      ErrOverrun <= (ErrOverrun & ~ErrClear) | w_overrun;
      ErrBadCmd  <= (ErrBadCmd & ~ErrClear) | w_bad;
      ErrTimeout <= (ErrTimeout & ~ErrClear) | w_tout;

      if ((r_state == c_IDLE) || ByteRecv) begin
        r_idle <= '0;
      end else if (!w_tout) begin
        r_idle <= r_idle + c_TW'(1);
      end

      if (w_ack) begin
        MemWe <= 1'b0;
      end
      if (w_data && !w_overrun) begin
        MemWe   <= 1'b1;
        MemAddr <= r_ptr;
        MemData <= ByteIn;
        r_ptr   <= r_ptr + 16'd1;
      end

      if (w_tout) begin
        r_state <= c_IDLE;
      end else if (ByteRecv) begin
        case (r_state)
          c_IDLE: begin
            r_cnt <= ByteIn[5:0];
            r_idx <= 2'd0;
            if (ByteIn[7:6] == 2'b01) begin
              r_state <= c_REG_PAY;
            end else if (ByteIn[7:6] == 2'b10) begin
              r_state <= c_MEM_ADDR;
            end
          end
          c_REG_PAY: begin
            r_pay <= {r_pay[7:0], ByteIn};
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd2) begin
              RegWe   <= 1'b1;
              RegAddr <= r_cnt;
              RegData <= {r_pay, ByteIn};
              r_state <= c_IDLE;
            end
          end
          c_MEM_ADDR: begin
            r_pay <= {r_pay[7:0], ByteIn};
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd1) begin
              r_ptr   <= {r_pay[7:0], ByteIn};
              r_state <= c_MEM_DATA;
            end
          end
          c_MEM_DATA: begin
            if (r_cnt == 6'd0) begin
              r_state <= c_IDLE;
            end else begin
              r_cnt <= r_cnt - 6'd1;
            end
          end
          default: r_state <= c_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_spi_cmd_decoder: self-checking bench for spi_cmd_decoder.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_spi_cmd_decoder;

  localparam int c_TO = 16;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        ByteRecv = 1'b0;
  logic [7:0]  ByteIn = 8'd0;
  logic        RegWe;
  logic [5:0]  RegAddr;
  logic [23:0] RegData;
  logic        MemWe;
  logic        MemAck = 1'b0;
  logic [15:0] MemAddr;
  logic [7:0]  MemData;
  logic        Busy;
  logic        ErrClear = 1'b0;
  logic        ErrOverrun, ErrBadCmd, ErrTimeout;

  spi_cmd_decoder #(.TimeoutCycles(c_TO)) dut (
    .Clk(Clk), .Reset(Reset), .ByteRecv(ByteRecv), .ByteIn(ByteIn),
    .RegWe(RegWe), .RegAddr(RegAddr), .RegData(RegData),
    .MemWe(MemWe), .MemAck(MemAck), .MemAddr(MemAddr), .MemData(MemData),
    .Busy(Busy), .ErrClear(ErrClear),
    .ErrOverrun(ErrOverrun), .ErrBadCmd(ErrBadCmd), .ErrTimeout(ErrTimeout)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  logic [29:0] obs_reg[$], exp_reg[$];
  logic [23:0] obs_mem[$], exp_mem[$];
  logic exp_bad, exp_tout;

  typedef struct {
    logic [5:0]  addr;
    logic [23:0] data;
  } rvec_t;
  rvec_t tbl[4];

  // Observed write transactions, sampled mid-cycle after the inputs settle
  always @(negedge Clk) begin
    #2;
    if (!Reset) begin
      if (RegWe) obs_reg.push_back({RegAddr, RegData});
      if (MemWe && MemAck) obs_mem.push_back({MemAddr, MemData});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    @(negedge Clk);
    ByteRecv = 1'b1;
    ByteIn   = b;
  endtask

  task automatic rel();
    @(negedge Clk);
    ByteRecv = 1'b0;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
    #1;
  endtask

  task automatic clr();
    @(negedge Clk);
    ErrClear = 1'b1;
    @(negedge Clk);
    ErrClear = 1'b0;
    #1;
  endtask

  task automatic cmp_queues(input string nm);
    chk($sformatf("%s reg count", nm), obs_reg.size(), exp_reg.size());
    for (int i = 0; i < obs_reg.size() && i < exp_reg.size(); i++)
      chk($sformatf("%s reg[%0d]", nm, i), {2'b0, obs_reg[i]}, {2'b0, exp_reg[i]});
    chk($sformatf("%s mem count", nm), obs_mem.size(), exp_mem.size());
    for (int i = 0; i < obs_mem.size() && i < exp_mem.size(); i++)
      chk($sformatf("%s mem[%0d]", nm, i), {8'b0, obs_mem[i]}, {8'b0, exp_mem[i]});
    obs_reg.delete(); exp_reg.delete(); obs_mem.delete(); exp_mem.delete();
  endtask

  initial begin
    tbl[0] = '{6'd1,  24'hC0C0C0};
    tbl[1] = '{6'd0,  24'h000000};
    tbl[2] = '{6'd63, 24'hFFFFFF};
    tbl[3] = '{6'd22, 24'h5A0F81};

    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    #1;
    chk("reset RegWe", RegWe, 0);
    chk("reset MemWe", MemWe, 0);
    chk("reset Busy", Busy, 0);
    chk("reset flags", {ErrOverrun, ErrBadCmd, ErrTimeout}, 0);
    chk("reset RegData", RegData, 0);
    chk("reset MemAddr", MemAddr, 0);

    // Register writes from the vector table
    for (int v = 0; v < 4; v++) begin
      put({2'b01, tbl[v].addr}); rel();
      chk($sformatf("tbl%0d busy", v), Busy, 1);
      put(tbl[v].data[23:16]); rel();
      put(tbl[v].data[15:8]);  rel();
      put(tbl[v].data[7:0]);   rel();
      chk($sformatf("tbl%0d RegWe", v), RegWe, 1);
      chk($sformatf("tbl%0d RegAddr", v), RegAddr, tbl[v].addr);
      chk($sformatf("tbl%0d RegData", v), RegData, tbl[v].data);
      chk($sformatf("tbl%0d busy end", v), Busy, 0);
      idle(1);
      chk($sformatf("tbl%0d RegWe pulse", v), RegWe, 0);
      chk($sformatf("tbl%0d RegData hold", v), RegData, tbl[v].data);
      exp_reg.push_back({tbl[v].addr, tbl[v].data});
    end
    cmp_queues("reg table");

    // MEM burst with acknowledge tied high
    MemAck = 1'b1;
    put(8'h82); rel(); put(8'h12); rel(); put(8'h34); rel();
    put(8'hAA); rel();
    chk("mem MemWe", MemWe, 1);
    chk("mem MemAddr", MemAddr, 16'h1234);
    chk("mem MemData", MemData, 8'hAA);
    put(8'hBB); rel(); put(8'hCC); rel();
    chk("mem busy end", Busy, 0);
    idle(2);
    chk("mem MemWe drop", MemWe, 0);
    exp_mem.push_back(24'h1234AA); exp_mem.push_back(24'h1235BB); exp_mem.push_back(24'h1236CC);
    cmp_queues("mem burst");

    // Address wrap, bytes back-to-back
    put(8'h81); put(8'hFF); put(8'hFF); put(8'h11); put(8'h22); rel();
    chk("wrap busy", Busy, 0);
    idle(2);
    exp_mem.push_back(24'hFFFF11); exp_mem.push_back(24'h000022);
    cmp_queues("wrap");

    // Truncated REG packet times out
    put(8'h41); rel(); put(8'hC0); rel();
    idle(c_TO - 3);
    chk("tout early busy", Busy, 1);
    idle(7);
    chk("tout busy", Busy, 0);
    chk("tout flag", ErrTimeout, 1);
    put(8'h41); rel(); put(8'h01); rel(); put(8'h02); rel(); put(8'h03); rel();
    exp_reg.push_back({6'd1, 24'h010203});
    idle(1);
    cmp_queues("timeout");

    // Overrun with acknowledge held low
    MemAck = 1'b0;
    clr();
    put(8'h81); rel(); put(8'h00); rel(); put(8'h10); rel();
    put(8'h55); rel(); put(8'h66); rel();
    chk("ovr MemWe held", MemWe, 1);
    chk("ovr MemAddr", MemAddr, 16'h0010);
    chk("ovr MemData", MemData, 8'h55);
    chk("ovr flag", ErrOverrun, 1);
    chk("ovr busy", Busy, 0);
    @(negedge Clk); MemAck = 1'b1;
    @(negedge Clk); MemAck = 1'b0;
    #1;
    chk("ovr MemWe drop", MemWe, 0);
    exp_mem.push_back(24'h001055);
    cmp_queues("overrun");
    clr();
    chk("ovr cleared", ErrOverrun, 0);

    // Reserved opcode, then a good packet
    put(8'hC5); rel();
    chk("bad flag", ErrBadCmd, 1);
    chk("bad busy", Busy, 0);
    put(8'h41); rel(); put(8'h00); rel(); put(8'h00); rel(); put(8'h07); rel();
    exp_reg.push_back({6'd1, 24'h000007});
    idle(1);
    cmp_queues("badcmd");
    clr();
    chk("bad cleared", ErrBadCmd, 0);
    @(negedge Clk);
    ByteRecv = 1'b1; ByteIn = 8'hC0; ErrClear = 1'b1;
    @(negedge Clk);
    ByteRecv = 1'b0; ErrClear = 1'b0;
    #1;
    chk("set beats clear", ErrBadCmd, 1);

    // Reset in the middle of a MEM packet
    MemAck = 1'b1;
    put(8'h82); rel(); put(8'h12); rel(); put(8'h34); rel();
    chk("rst pre busy", Busy, 1);
    @(negedge Clk); Reset = 1'b1;
    @(negedge Clk); Reset = 1'b0;
    #1;
    chk("rst busy", Busy, 0);
    chk("rst outs", {RegWe, MemWe, ErrOverrun, ErrBadCmd, ErrTimeout}, 0);
    chk("rst RegAddr", RegAddr, 0);
    chk("rst RegData", RegData, 0);
    chk("rst MemAddr", MemAddr, 0);
    chk("rst MemData", MemData, 0);
    cmp_queues("reset");

    // Randomized packets against a packet-level reference model
    exp_bad = 1'b0;
    exp_tout = 1'b0;
    for (int p = 0; p < 60; p++) begin
      int r, cut, g;
      logic [7:0] h;
      logic [7:0] pay[$];
      logic [15:0] a;
      r = $urandom_range(0, 9);
      pay.delete();
      if (r < 4) begin
        h = {2'b01, 6'($urandom_range(0, 63))};
        for (int i = 0; i < 3; i++) pay.push_back(8'($urandom));
      end else if (r < 8) begin
        h = {2'b10, 6'($urandom_range(0, 5))};
        a = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
        pay.push_back(a[15:8]); pay.push_back(a[7:0]);
        for (int i = 0; i <= int'(h[5:0]); i++) pay.push_back(8'($urandom));
      end else if (r == 8) begin
        h = {2'b00, 6'($urandom_range(0, 63))};
      end else begin
        h = {2'b11, 6'($urandom_range(0, 63))};
        exp_bad = 1'b1;
      end
      cut = pay.size();
      if (pay.size() > 0 && $urandom_range(0, 6) == 0) cut = $urandom_range(0, pay.size() - 1);

      for (int i = 0; i <= cut; i++) begin
        put((i == 0) ? h : pay[i - 1]);
        g = $urandom_range(0, 3);
        if (g > 0) begin rel(); if (g > 1) idle(g - 1); end
      end
      if (ByteRecv) rel();
      if (cut < pay.size()) begin
        idle(c_TO + 4);
        exp_tout = 1'b1;
      end else begin
        idle($urandom_range(0, 2));
      end

      if (h[7:6] == 2'b01 && cut == 3) begin
        exp_reg.push_back({h[5:0], pay[0], pay[1], pay[2]});
      end else if (h[7:6] == 2'b10) begin
        a = {pay[0], pay[1]};
        for (int i = 0; i < cut - 2; i++) exp_mem.push_back({a + 16'(i), pay[2 + i]});
      end
    end
    idle(3);
    cmp_queues("random");
    chk("random bad flag", ErrBadCmd, exp_bad);
    chk("random tout flag", ErrTimeout, exp_tout);
    chk("random ovr flag", ErrOverrun, 0);
    chk("random busy", Busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_cmd_decoder.md
# spi_cmd_decoder

Command decoder directly downstream of the `spi` byte receiver. It consumes the received-byte stream (`ByteRecv` strobe plus `ByteOut` data), frames it into command packets by header byte, and issues register writes and framebuffer memory writes to the rest of the VGA core. It also recovers from truncated packets with an inter-byte timeout and reports errors through sticky flags.

## Interface
- `TimeoutCycles`, 25000: idle `Clk` cycles between bytes of an open packet before it is abandoned (100 us at 250 MHz); must be >= 2.
- `Clk`  in  1  system clock; same clock that drives `spi`.
- `Reset`  in  1  synchronous, active-high reset.
- `ByteRecv`  in  1  one-cycle strobe from `spi`; `ByteIn` is valid in that cycle.
- `ByteIn`  in  8  received byte, MSB-first as shifted in by `spi`.
- `RegWe`  out  1  one-cycle register write strobe.
- `RegAddr`  out  6  register index.
- `RegData`  out  24  register value.
- `MemWe`  out  1  memory write request; held until acknowledged.
- `MemAck`  in  1  memory accepts the write in any cycle where `MemWe` and `MemAck` are both high.
- `MemAddr`  out  16  pixel address.
- `MemData`  out  8  pixel value (RGB332).
- `Busy`  out  1  high while a packet is open (state not IDLE).
- `ErrClear`  in  1  clears all error flags.
- `ErrOverrun`, `ErrBadCmd`, `ErrTimeout`  out  1 each  sticky error flags.

## Operation
- Header byte H: H[7:6] is the opcode, H[5:0] is the argument.
  - 00 NOP: no payload; stay in IDLE.
  - 01 REG: 3 payload bytes, big-endian, form `RegData`; `RegAddr` = H[5:0].
  - 10 MEM: 2 address bytes (big-endian start address), then N = H[5:0]+1 data bytes.
  - 11 reserved: set `ErrBadCmd`; the byte is discarded; stay in IDLE.
- States:
  - IDLE: a byte is a header.
  - REG_PAY: byte index 0..2; after index 2, pulse `RegWe`, then go to IDLE.
  - MEM_ADDR: index 0..1; after index 1, load the address pointer, then go to MEM_DATA.
  - MEM_DATA: remaining-count register, 6 bits; go to IDLE after the Nth data byte.
- Memory write path:
  - Each data byte loads a one-deep output register (`MemData`, `MemAddr` = pointer) and raises `MemWe`.
  - On acknowledge, drop `MemWe` and increment the pointer modulo 2^16 (0xFFFF wraps to 0x0000).
  - The pointer is retained when the packet ends; MEM always reloads it from its own address bytes.
- Overrun:
  - Condition: a data byte arrives while `MemWe` is high and `MemAck` is low that cycle.
  - Response: drop the byte, set `ErrOverrun`, still decrement the count, and do not advance the pointer.
  - If `MemAck` is high in the same cycle, it is a normal accept and the new byte loads.
- Packet end with a write still pending: the write stays pending; a new packet may start regardless.
- Timeout:
  - An idle counter runs in any non-IDLE state and is cleared on every `ByteRecv`.
  - On reaching `TimeoutCycles`: go to IDLE, set `ErrTimeout`, discard partial payload, issue no `RegWe`.
  - Any pending `MemWe` is unaffected.
- Error flags: sticky until `ErrClear`. If `ErrClear` and a new error event occur in the same cycle, the set wins.

## Timing
- Reset values: all outputs are 0, state is IDLE, the pointer and counters are 0.
- REG latency: `RegWe` is high for exactly 1 cycle, in the cycle after the `ByteRecv` of the 3rd payload byte. `RegAddr` and `RegData` are stable in that cycle and hold afterwards.
- MEM latency: `MemWe` rises in the cycle after the data byte's `ByteRecv`. The earliest acknowledge is that same cycle. `MemWe` falls in the cycle after the acknowledge.
- `Busy` rises in the cycle after a REG/MEM header strobe. It falls in the cycle after the final byte, or the cycle after the timeout fires.
- Timeout fires `TimeoutCycles` cycles after the last `ByteRecv`, ±1 cycle allowed.
- Back-to-back `ByteRecv` on consecutive cycles must be handled, although `spi` never produces this.
- `Reset` mid-packet: the next cycle is IDLE, with no write issued and all flags cleared.

## Test plan
- Send 41 C0 C0 C0 -> one `RegWe` pulse with `RegAddr`=1 and `RegData`=0xC0C0C0; `Busy` low afterwards.
- Send 82 12 34 AA BB CC with `MemAck` tied high -> writes 0x1234:AA, 0x1235:BB, 0x1236:CC; then IDLE.
- Send 81 FF FF 11 22 -> writes 0xFFFF:11 and 0x0000:22 (wrap).
- Send 41 C0, then idle longer than `TimeoutCycles`, then 41 01 02 03 -> `ErrTimeout`=1, no write for the first packet, then `RegData`=0x010203 to register 1.
- Send 81 00 10 55 66 with `MemAck` held low -> `MemWe` held with 0x0010:55, `ErrOverrun`=1, 66 dropped. Then raise `MemAck` -> one write completes. Then `ErrClear` -> flag cleared.
- Send C5 then 41 00 00 07 -> `ErrBadCmd`=1, followed by a correct write of 0x000007 to register 1. Assert `Reset` mid-MEM packet -> outputs are 0 and `Busy`=0 on the next cycle.
